// File: rtl/axiline_seq_pkg.sv
// Shared types and constants for the Axiline memory sequencer.
// Imported by the sequencer and its bench.
package axiline_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_W,
    S_RUN,
    S_COMMIT,
    S_RD_ADDR,
    S_RD_LAT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0] WEA_X = 2'b01;
  localparam logic [1:0] WEA_W = 2'b10;

  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axiline_mem_sequencer.sv
// Loads x/w BRAMs from a word stream, runs the accelerator,
// then drains the output BRAM into a result stream.
module axiline_mem_sequencer
  import axiline_seq_pkg::*;
#(
  parameter int WORDS_X    = 32,
  parameter int WORDS_W    = 32,
  parameter int RUN_CYCLES = 16,
  parameter int OUT_DEPTH  = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data_in_mem,
  output logic [1:0]        wea,
  output logic              start,
  output logic              r_w,
  output logic [ADDR_W-1:0] addr_out,
  input  logic [63:0]       data_out
);

  localparam int WMAX = (WORDS_X > WORDS_W) ? WORDS_X : WORDS_W;
  localparam int CW   = cw(WMAX);
  localparam int RW   = cw(RUN_CYCLES);
  localparam int KW   = cw(OUT_DEPTH);

  localparam logic [CW-1:0] X_LAST = CW'(WORDS_X - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WORDS_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RUN_CYCLES);
  localparam logic [KW-1:0] K_LAST = KW'(OUT_DEPTH - 1);

  if (WORDS_X > 2**ADDR_W || WORDS_W > 2**ADDR_W ||
      OUT_DEPTH > 2**ADDR_W || RUN_CYCLES < 1) begin : g_chk
    $error("axiline_mem_sequencer: bad parameters");
  end

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [RW-1:0] run_cnt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_inc;
  logic          load;
  logic          hs;
  logic          drain_hs;

  assign load     = (state == S_LOAD_X) || (state == S_LOAD_W);
  assign hs       = load & in_valid & in_ready;
  assign drain_hs = (state == S_HOLD) & out_ready;
  assign k_inc    = k + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    if (go) next = S_LOAD_X;
      S_LOAD_X:  if (hs && cnt == X_LAST) next = S_LOAD_W;
      S_LOAD_W:  if (hs && cnt == W_LAST) next = S_RUN;
      S_RUN:     if (run_cnt == R_LAST) next = S_COMMIT;
      S_COMMIT:  next = S_RD_ADDR;
      S_RD_ADDR: next = S_RD_LAT;
      S_RD_LAT:  next = S_HOLD;
      S_HOLD: begin
        if (out_ready)
          next = (k == K_LAST) ? S_DONE : S_RD_ADDR;
      end
      S_DONE:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  // RUN lasts one cycle longer than start: its first cycle is the
  // last write reaching the BRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      run_cnt <= '0;
      k       <= '0;
    end else begin
      if (state == S_IDLE)
        cnt <= '0;
      else if (hs)
        cnt <= (next != state) ? '0 : cnt + 1'b1;
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
      if (state == S_IDLE)
        k <= '0;
      else if (drain_hs)
        k <= k_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wea         <= '0;
      addr        <= '0;
      data_in_mem <= '0;
      start       <= 1'b0;
      r_w         <= 1'b0;
      addr_out    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      in_ready <= (next == S_LOAD_X) || (next == S_LOAD_W);
      busy     <= next != S_IDLE;
      done     <= next == S_DONE;
      start    <= (state == S_RUN) && (next == S_RUN);
      r_w      <= next == S_COMMIT;
      wea      <= '0;
      if (hs) begin
        wea         <= (state == S_LOAD_X) ? WEA_X : WEA_W;
        addr        <= ADDR_W'(cnt);
        data_in_mem <= in_data;
      end
      if (next == S_RD_ADDR)
        addr_out <= ADDR_W'((state == S_HOLD) ? k_inc : k);
      else if (next == S_COMMIT)
        addr_out <= '0;
      if (state == S_RD_LAT) begin
        out_data  <= data_out;
        out_valid <= 1'b1;
      end else if (drain_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axiline_mem_sequencer.sv
// Randomized scoreboard bench for axiline_mem_sequencer with
// BRAM and accelerator-commit models.
module tb_axiline_mem_sequencer;
  import axiline_seq_pkg::*;

  localparam int WX = 32;
  localparam int WW = 32;
  localparam int RC = 16;
  localparam int OD = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr;
  logic [31:0]   data_in_mem;
  logic [1:0]    wea;
  logic          start;
  logic          r_w;
  logic [AW-1:0] addr_out;
  logic [63:0]   data_out;

  always #5 clk = ~clk;

  axiline_mem_sequencer #(
    .WORDS_X(WX), .WORDS_W(WW), .RUN_CYCLES(RC),
    .OUT_DEPTH(OD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .addr(addr),
    .data_in_mem(data_in_mem), .wea(wea), .start(start),
    .r_w(r_w), .addr_out(addr_out), .data_out(data_out)
  );

  // Output BRAM: the accelerator commits its results on r_w,
  // reads have one cycle of latency.
  logic [63:0] obram [256];
  logic [63:0] res [OD];

  always @(posedge clk) begin
    if (r_w)
      for (int i = 0; i < OD; i++) obram[i] <= res[i];
    data_out <= obram[addr_out];
  end

  logic [41:0] wq [$];
  logic [63:0] oq [$];
  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h required nothing", nm, act);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {in_ready, out_valid, busy, done, wea,
                       start, r_w, addr, addr_out}, '0);
    chk({nm, "_odata"}, out_data, '0);
    chk({nm, "_wdata"}, {32'h0, data_in_mem}, '0);
  endtask

  // Monitor: pops the scoreboard and checks job timing.
  int          cyc = 0;
  int          acc = 0;
  int          lastw = 0;
  int          run_len = 0;
  int          done_cnt = 0;
  int          last_hs = 0;
  bit          have_hs = 0;
  bit          start_prev = 0;
  bit          hold_prev = 0;
  bit          first_ov = 0;
  logic [63:0] prev_data;
  logic [AW-1:0] prev_ao;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      acc = 0; run_len = 0; start_prev = 0;
      hold_prev = 0; first_ov = 0; have_hs = 0;
    end else begin
      if (wea != 2'b00) begin
        if (wq.size() == 0) miss("wr_extra", {wea, addr, data_in_mem});
        else chk("write", {wea, addr, data_in_mem}, wq.pop_front());
      end
      if (in_valid && in_ready) begin
        acc++;
        if (acc == WX + WW) lastw = cyc;
      end
      if (start && !start_prev) chk("start_rise", cyc, lastw + 2);
      if (start) run_len++;
      start_prev = start;
      if (r_w) begin
        chk("run_len", run_len, RC);
        chk("rw_time", cyc, lastw + 2 + RC);
        run_len = 0;
      end
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_addr", addr_out, prev_ao);
      end
      if (out_valid && !first_ov) begin
        first_ov = 1;
        chk("first_ov", cyc, lastw + 5 + RC);
      end
      if (out_valid && out_ready) begin
        if (rdy_mode == 0 && have_hs) chk("drain_gap", cyc - last_hs, 3);
        have_hs = 1;
        last_hs = cyc;
        if (oq.size() == 0) miss("out_extra", out_data);
        else chk("out", out_data, oq.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_ao   = addr_out;
      if (done) begin
        done_cnt++;
        acc = 0; first_ov = 0; have_hs = 0;
      end
    end
  end

  // gapmode: 0 continuous, 1 toggling, 2 random in_valid.
  // rmode: 0 out_ready high, 1 random, 2 seven-cycle stall.
  task automatic job(input int gapmode, input int rmode, input bit dead,
                     input bit go_run, input bit do_rst);
    logic [31:0] xw [WX];
    logic [31:0] ww [WW];
    logic [31:0] d;
    logic [31:0] salt;
    logic [1:0]  wv;
    bit          ok;
    bit          tog;
    bit          went;
    int          tmo;
    int          n;
    int          stallc;
    int          dc0;
    rdy_mode = rmode;
    tog = 1;
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 0);
    @(posedge clk) #1 go = 1;
    @(negedge clk) chk("go_ready0", in_ready, 0);
    @(posedge clk) #1 go = 0;
    @(negedge clk);
    chk("go_ready1", in_ready, 1);
    chk("go_busy", busy, 1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < ((b == 0) ? WX : WW); i++) begin
        if (do_rst && b == 1 && i == 10) begin
          @(posedge clk) #1 in_valid = 0;
          #2 rst = 0;
          #1 chk_zero("rst_mid");
          wq.delete();
          oq.delete();
          repeat (2) @(posedge clk);
          #3 rst = 1;
          return;
        end
        d = (dead && b == 0 && i == 5) ? 32'hDEADBEEF : $urandom;
        if (b == 0) xw[i] = d; else ww[i] = d;
        wv = (b == 0) ? WEA_X : WEA_W;
        ok = 0;
        tmo = 0;
        while (!ok) begin
          @(posedge clk) #1;
          in_data = d;
          if (gapmode == 1) in_valid = tog;
          else if (gapmode == 2) in_valid = 1'($urandom_range(0, 1));
          else in_valid = 1;
          tog = ~tog;
          @(negedge clk);
          if (in_valid && in_ready) begin
            ok = 1;
            wq.push_back({wv, AW'(i), d});
          end else if (++tmo > 50) begin
            miss("load_timeout", 64'(i));
            in_valid = 0;
            return;
          end
        end
      end
    end
    salt = $urandom;
    for (int i = 0; i < OD; i++) begin
      res[i] = {xw[i] ^ salt, ww[i]};
      oq.push_back(res[i]);
    end
    dc0 = done_cnt;
    n = 0;
    stallc = 0;
    went = 0;
    while (done_cnt == dc0 && n < 400) begin
      @(posedge clk) #1;
      in_valid = 0;
      go = go_run && start && !went;
      if (go) went = 1;
      if (rmode == 2) out_ready = (stallc >= 7);
      else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1;
      @(negedge clk);
      n++;
      if (out_valid && !out_ready) stallc++;
    end
    if (n >= 400) miss("job_timeout", 64'(n));
    go = 0;
    repeat (5) @(negedge clk);
    if (go_run) chk("go_seen", went, 1);
    if (rmode == 2) chk("stall_len", stallc, 7);
    chk("done_once", done_cnt - dc0, 1);
    chk("wq_empty", wq.size(), 0);
    chk("oq_empty", oq.size(), 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    rst = 0;
    go = 0;
    in_valid = 0;
    in_data = 0;
    out_ready = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk) #1 rst = 1;
    job(0, 0, 0, 0, 0);
    job(1, 1, 1, 0, 0);
    job(2, 2, 0, 0, 0);
    job(0, 1, 0, 1, 0);
    job(0, 0, 0, 0, 1);
    job(0, 0, 1, 0, 0);
    for (int j = 0; j < 3; j++)
      job(2, 1, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axiline_mem_sequencer.md
# axiline_mem_sequencer

Host-side controller for the Axiline accelerator's block-memory port. It accepts a valid/ready stream of 32-bit words and writes them into the input-x and weight BRAMs (wea/addr/data_in_mem). It then holds the accelerator's `start` for a fixed compute window, commits the result with `r_w`, and drains the 64-bit output BRAM through `addr_out` into a valid/ready output stream. It sits between the host bus adapter and the accelerator wrapper and drives the wrapper's ports from the other side.

## Interface
- WORDS_X, 32, 32-bit words written to the x bank per job
- WORDS_W, 32, 32-bit words written to the weight bank per job
- RUN_CYCLES, 16, cycles `start` is held high (≥1)
- OUT_DEPTH, 4, 64-bit output words drained per job
- ADDR_W, 8, width of `addr`/`addr_out`
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- go  in  1  pulse: begin a job (sampled only in IDLE)
- in_data  in  32  load word
- in_valid  in  1  load word valid
- in_ready  out  1  sequencer accepts load word
- out_data  out  64  drained result word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last result handshake
- addr  out  ADDR_W  x/w BRAM write address
- data_in_mem  out  32  x/w BRAM write data
- wea  out  2  bit0 x bank, bit1 weight bank
- start  out  1  accelerator run enable
- r_w  out  1  output-BRAM write enable (commit)
- addr_out  out  ADDR_W  output-BRAM address
- data_out  in  64  output-BRAM read data, 1-cycle read latency

## Operation
- States: IDLE, LOAD_X, LOAD_W, RUN, COMMIT, RD_ADDR, RD_LAT, HOLD, DONE.
- IDLE: `go`=1 moves to LOAD_X, clears counters. `go` outside IDLE is ignored.
- LOAD_X/LOAD_W: `in_ready`=1. Each handshake (in_valid & in_ready) registers `addr`=word index (zero-extended, restarts at 0 per bank), `data_in_mem`=in_data, and `wea`=2'b01 (X) or 2'b10 (W) for exactly one cycle. `wea`=0 in all other cycles. After handshake WORDS_X-1 go to LOAD_W. After handshake WORDS_W-1 go to RUN. Gaps in in_valid stall the count and produce no write.
- RUN: `start`=1 for exactly RUN_CYCLES cycles, then COMMIT.
- COMMIT: one cycle with `r_w`=1, `addr_out`=0, `start`=0.
- RD_ADDR: drive `addr_out`=k, where k is the drain index, 0..OUT_DEPTH-1.
- RD_LAT: the BRAM returns data. Latch it into `out_data` and set `out_valid`, then go to HOLD.
- HOLD: hold `out_data`/`out_valid` stable until out_ready. On handshake, k++. Go to RD_ADDR if k<OUT_DEPTH, otherwise DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Counters use ceil(log2(max+1)) bits. Addresses wrap never occurs: an elaboration check requires WORDS_X, WORDS_W, OUT_DEPTH ≤ 2^ADDR_W.

## Timing
- All outputs are registered. Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, addr 0, data_in_mem 0, wea 0, start 0, r_w 0, addr_out 0.
- `go` at cycle t: in_ready=1 from t+1.
- Load word accepted at cycle t: appears on addr/data_in_mem/wea at t+1.
- Last W word accepted at t: its write occurs at t+1. `start` is high over t+2 … t+1+RUN_CYCLES. `r_w` is high at t+2+RUN_CYCLES. First `addr_out` read is issued at t+3+RUN_CYCLES. First out_valid is at t+5+RUN_CYCLES.
- Drain throughput: 3 cycles per word with out_ready held high.
- An asynchronous reset in any state returns to IDLE next edge-free. All outputs go to reset values immediately, and a partial load is abandoned.
- in_valid & in_ready in the same cycle as the state transition counts once. There is no double write.

## Structure
- Shared package `axiline_seq_pkg`: state enum, WEA_X=2'b01, WEA_W=2'b10 constants.
- Single module, no sub-module. The drain output register is inline.

## Test plan
- Reset mid-LOAD_W after 10 words: all outputs 0. The next `go` restarts at addr 0 of the x bank.
- Nominal job (WORDS_X=WORDS_W=32, RUN_CYCLES=16, OUT_DEPTH=4) with continuous in_valid: 32 writes with wea=01 at addr 0..31, then 32 writes with wea=10 at addr 0..31. `start` is high for exactly 16 cycles, then one `r_w` pulse. Four out words equal the BRAM model contents at 0..3. `done` pulses once.
- in_valid toggling 1/0: no wea pulse in idle cycles, and addresses remain contiguous.
- out_ready held low for 7 cycles in HOLD: out_data/out_valid are stable and addr_out is not advanced.
- `go` asserted during RUN: ignored, and the job completes normally with exactly one `done`.
- in_data=32'hDEADBEEF as X word 5: addr=5, data_in_mem=DEADBEEF, and wea=01 in the following cycle only.
